// File: rtl/rr_mux_sel.sv
// Registered N-to-1 round-robin channel multiplexer with valid/ready on every port.
// Define RR_MUX_SEL_LOCK_EN to add in_last/out_last and burst locking to the granted channel.
module rr_mux_sel #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       in_valid_i,
    input  logic [NUM_CH*WIDTH-1:0] in_data_i,
    output logic [NUM_CH-1:0]       in_ready_o,
    output logic                    out_valid_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_ch_o,
`ifdef RR_MUX_SEL_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last_i,
    output logic                    out_last_o,
`endif
    input  logic                    out_ready_i
);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0]     out_ch_q, out_ch_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;

    logic                 load;
    logic                 any_req;
    logic                 fire;
    logic [NUM_CH-1:0]    req;
    logic [2*NUM_CH-1:0]  req2;
    logic [NUM_CH-1:0]    rot;
    logic [SEL_W:0]       off;
    logic [SEL_W:0]       sum;
    logic [SEL_W:0]       grant_inc;
    logic [SEL_W-1:0]     grant;
    logic [SEL_W-1:0]     grant_next;
    logic [WIDTH-1:0]     sel_data;

`ifdef RR_MUX_SEL_LOCK_EN
    typedef enum logic {StArb, StLocked} state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     lock_ch_q, lock_ch_d;
    logic                 out_last_q, out_last_d;
    logic                 sel_last;
`endif

    // Request mask: while locked only the owning channel may compete.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef RR_MUX_SEL_LOCK_EN
            req[i] = in_valid_i[i] & ((state_q == StArb) | (lock_ch_q == SEL_W'(i)));
`else
            req[i] = in_valid_i[i];
`endif
        end
    end

    // Rotate requests so bit 0 is the pointer position, then take the first set bit.
    always_comb begin
        req2    = {req, req};
        rot     = NUM_CH'(req2 >> ptr_q);
        any_req = 1'b0;
        off     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!any_req && rot[k]) begin
                any_req = 1'b1;
                off     = (SEL_W+1)'(k);
            end
        end
        sum = {1'b0, ptr_q} + off;
        if (sum >= (SEL_W+1)'(NUM_CH)) begin
            sum = sum - (SEL_W+1)'(NUM_CH);
        end
        grant     = sum[SEL_W-1:0];
        grant_inc = {1'b0, grant} + (SEL_W+1)'(1);
        if (grant_inc == (SEL_W+1)'(NUM_CH)) begin
            grant_inc = '0;
        end
        grant_next = grant_inc[SEL_W-1:0];
    end

    always_comb begin
        sel_data = '0;
`ifdef RR_MUX_SEL_LOCK_EN
        sel_last = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_data = in_data_i[i*WIDTH +: WIDTH];
`ifdef RR_MUX_SEL_LOCK_EN
                sel_last = in_last_i[i];
`endif
            end
        end
    end

    // Reset gating keeps in_ready low while rst_ni is held, even though load is high.
    always_comb begin
        load = ~out_valid_q | out_ready_i;
        fire = load & any_req & rst_ni;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            in_ready_o[i] = fire & (grant == SEL_W'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
`ifdef RR_MUX_SEL_LOCK_EN
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        out_last_d  = out_last_q;
`endif
        if (load) begin
            if (any_req) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_ch_d    = grant;
`ifdef RR_MUX_SEL_LOCK_EN
                out_last_d  = sel_last;
                if (state_q == StArb) begin
                    ptr_d = grant_next;
                    if (!sel_last) begin
                        state_d   = StLocked;
                        lock_ch_d = grant;
                    end
                end else if (sel_last) begin
                    state_d = StArb;
                    ptr_d   = grant_next;
                end
`else
                ptr_d       = grant_next;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
`ifdef RR_MUX_SEL_LOCK_EN
            state_q     <= StArb;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
`ifdef RR_MUX_SEL_LOCK_EN
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
`ifdef RR_MUX_SEL_LOCK_EN
    assign out_last_o  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_mux_sel.sv
// Directed, table-driven bench for rr_mux_sel (4 channels x 32 bits).
// Burst-lock sequences are exercised only when RR_MUX_SEL_LOCK_EN is defined.
module tb_rr_mux_sel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [127:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_ch;
    logic        out_ready;
`ifdef RR_MUX_SEL_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int checks = 0;
    int errors = 0;

    rr_mux_sel #(
        .WIDTH  (32),
        .NUM_CH (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
`ifdef RR_MUX_SEL_LOCK_EN
        .in_last_i   (in_last),
        .out_last_o  (out_last),
`endif
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [1:0]  exp_ch;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Inputs change at posedge+1; in_ready checked 1ns later, registers checked after the edge.
    task automatic apply(input string name, input logic [3:0] valid, input logic rdy,
                         input logic [3:0] exp_rdy, input logic exp_ov,
                         input logic [31:0] exp_data, input logic [1:0] exp_ch);
        in_valid  = valid;
        out_ready = rdy;
        #1;
        chk({name, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        chk({name, ".out_valid"}, 64'(out_valid), 64'(exp_ov));
        chk({name, ".out_data"}, 64'(out_data), 64'(exp_data));
        chk({name, ".out_ch"}, 64'(out_ch), 64'(exp_ch));
    endtask

    initial begin
        vecs[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 32'hA0, 2'd0};
        vecs[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 32'hA1, 2'd1};
        vecs[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 32'hA2, 2'd2};
        vecs[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 32'hA3, 2'd3};
        vecs[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 32'hA0, 2'd0};
        vecs[5]  = '{4'h2, 1'b1, 4'h2, 1'b1, 32'hA1, 2'd1};
        vecs[6]  = '{4'hA, 1'b1, 4'h8, 1'b1, 32'hA3, 2'd3};
        vecs[7]  = '{4'hA, 1'b1, 4'h2, 1'b1, 32'hA1, 2'd1};
        vecs[8]  = '{4'hA, 1'b1, 4'h8, 1'b1, 32'hA3, 2'd3};
        vecs[9]  = '{4'hA, 1'b1, 4'h2, 1'b1, 32'hA1, 2'd1};
        vecs[10] = '{4'h0, 1'b1, 4'h0, 1'b0, 32'hA1, 2'd1};
        vecs[11] = '{4'h0, 1'b1, 4'h0, 1'b0, 32'hA1, 2'd1};
        vecs[12] = '{4'hF, 1'b1, 4'h4, 1'b1, 32'hA2, 2'd2};
        vecs[13] = '{4'hF, 1'b0, 4'h0, 1'b1, 32'hA2, 2'd2};
        vecs[14] = '{4'hF, 1'b0, 4'h0, 1'b1, 32'hA2, 2'd2};
        vecs[15] = '{4'hF, 1'b1, 4'h8, 1'b1, 32'hA3, 2'd3};

        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA0 + 32'(i);
`ifdef RR_MUX_SEL_LOCK_EN
        in_last = 4'hF;
`endif

        // Reset held with every channel requesting.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'h0);
        chk("rst.out_valid", 64'(out_valid), 64'h0);
        chk("rst.out_data", 64'(out_data), 64'h0);
        chk("rst.out_ch", 64'(out_ch), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Rotation, sparse/wrap, idle with pointer hold, short stall.
        for (int i = 0; i < 16; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].valid, vecs[i].rdy, vecs[i].exp_rdy,
                  vecs[i].exp_ov, vecs[i].exp_data, vecs[i].exp_ch);
        end

        // Backpressure: hold 0x11 for three stalled cycles, then drain and refill together.
        in_data[3*32 +: 32] = 32'h11;
        apply("bp.load", 4'h8, 1'b1, 4'h8, 1'b1, 32'h11, 2'd3);
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("bp.stall%0d", i), 4'hF, 1'b0, 4'h0, 1'b1, 32'h11, 2'd3);
        end
        apply("bp.refill", 4'hF, 1'b1, 4'h1, 1'b1, 32'hA0, 2'd0);
        in_data[3*32 +: 32] = 32'hA3;

`ifdef RR_MUX_SEL_LOCK_EN
        // Burst on channel 2 with a gap; channel 0 must wait until in_last.
        in_last = 4'h0;
        apply("lk.b0", 4'h4, 1'b1, 4'h4, 1'b1, 32'hA2, 2'd2);
        chk("lk.b0.last", 64'(out_last), 64'h0);
        apply("lk.b1", 4'h5, 1'b1, 4'h4, 1'b1, 32'hA2, 2'd2);
        chk("lk.b1.last", 64'(out_last), 64'h0);
        apply("lk.gap", 4'h1, 1'b1, 4'h0, 1'b0, 32'hA2, 2'd2);
        in_last = 4'h4;
        apply("lk.b2", 4'h5, 1'b1, 4'h4, 1'b1, 32'hA2, 2'd2);
        chk("lk.b2.last", 64'(out_last), 64'h1);
        in_last = 4'hF;
        apply("lk.ch0", 4'h5, 1'b1, 4'h1, 1'b1, 32'hA0, 2'd0);
        chk("lk.ch0.last", 64'(out_last), 64'h1);
        in_last = 4'h0;
        apply("lk.relock", 4'h4, 1'b1, 4'h4, 1'b1, 32'hA2, 2'd2);
`endif

        // Mid-operation reset with a beat held (and, with locking, while locked).
        in_valid = 4'hF;
        rst_n    = 1'b0;
        #1;
        chk("mrst.out_valid", 64'(out_valid), 64'h0);
        chk("mrst.in_ready", 64'(in_ready), 64'h0);
        chk("mrst.out_data", 64'(out_data), 64'h0);
`ifdef RR_MUX_SEL_LOCK_EN
        chk("mrst.out_last", 64'(out_last), 64'h0);
        in_last = 4'hF;
`endif
        @(posedge clk);
        #1;
        chk("mrst.hold_valid", 64'(out_valid), 64'h0);
        rst_n = 1'b1;
        apply("mrst.first", 4'hF, 1'b1, 4'h1, 1'b1, 32'hA0, 2'd0);
        apply("mrst.second", 4'hF, 1'b1, 4'h2, 1'b1, 32'hA1, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
